q8_24_lif_neuron: RTL

Leaky integrate-and-fire neuron that consumes Q8.24 synaptic current samples and produces spike pulses. It sits directly downstream of the Q8_24_multiplier, which it instantiates to apply the membrane leak factor. Each accepted sample updates the membrane potential as v ← sat(LEAK·v + I). Crossing the threshold emits a one-cycle spike, resets the potential and enters a refractory window. The block is the per-neuron state element of the spiking core.

---
 rtl/q8_24_pkg.sv | 29 ++
 rtl/q8_24_lif_neuron_if.sv | 32 +++
 rtl/Q8_24_multiplier.sv | 23 ++
 rtl/q8_24_lif_neuron.sv | 99 +++++++++
 4 files changed

// File: rtl/q8_24_pkg.sv
// Shared Q8.24 fixed-point definitions for the neuron datapath.
package q8_24_pkg;

  localparam int unsigned Q_FRAC  = 24;
  localparam int unsigned Q_WIDTH = 32;

  localparam logic signed [Q_WIDTH-1:0] Q_MAX = 32'sh7FFFFFFF;
  localparam logic signed [Q_WIDTH-1:0] Q_MIN = 32'sh80000000;
  localparam logic signed [Q_WIDTH-1:0] Q_ONE = 32'sh01000000;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    REFRACT
  } lif_state_e;

  // Signed add with clamping to the representable Q8.24 range.
  function automatic logic signed [Q_WIDTH-1:0] sat_add(input logic signed [Q_WIDTH-1:0] a,
                                                         input logic signed [Q_WIDTH-1:0] b);
    logic [Q_WIDTH:0] sum;
    sum = {a[Q_WIDTH-1], a} + {b[Q_WIDTH-1], b};
    // Overflow shows up as a disagreement between the two top bits of the 33-bit sum.
    if (sum[Q_WIDTH] != sum[Q_WIDTH-1]) begin
      return sum[Q_WIDTH] ? Q_MIN : Q_MAX;
    end
    return sum[Q_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/q8_24_lif_neuron_if.sv
// Sample input handshake plus neuron status outputs.
interface q8_24_lif_neuron_if;
  import q8_24_pkg::*;

  logic                      in_valid;
  logic signed [Q_WIDTH-1:0] in_current;
  logic                      in_ready;
  logic                      spike;
  logic signed [Q_WIDTH-1:0] v_mem;
  logic                      refractory;

  // Upstream current source / observer.
  modport master (
    output in_valid,
    output in_current,
    input  in_ready,
    input  spike,
    input  v_mem,
    input  refractory
  );

  // The neuron itself.
  modport slave (
    input  in_valid,
    input  in_current,
    output in_ready,
    output spike,
    output v_mem,
    output refractory
  );

endinterface

// File: rtl/Q8_24_multiplier.sv
// Combinational Q8.24 multiply; truncates toward -inf, no rounding, no saturation.
module Q8_24_multiplier
  import q8_24_pkg::*;
(
  input  logic signed [Q_WIDTH-1:0] a,
  input  logic signed [Q_WIDTH-1:0] b,
  output logic signed [Q_WIDTH-1:0] prod
);

  logic signed [2*Q_WIDTH-1:0] full;
  logic                        unused_bits;

  // Full-precision signed product; both operands sign-extended before multiplying.
  always_comb begin
    full = 64'(a) * 64'(b);
  end

  assign prod = full[Q_FRAC+Q_WIDTH-1:Q_FRAC];

  // Integer overflow bits and sub-LSB fraction are intentionally discarded.
  assign unused_bits = ^{full[2*Q_WIDTH-1:Q_FRAC+Q_WIDTH], full[Q_FRAC-1:0]};

endmodule

// File: rtl/q8_24_lif_neuron.sv
// Leaky integrate-and-fire neuron: v <- sat(LEAK*v + I), spike and refractory on threshold.
module q8_24_lif_neuron
  import q8_24_pkg::*;
#(
  parameter logic signed [31:0] THRESHOLD      = 32'sh01000000,
  parameter logic signed [31:0] V_RESET        = 32'sh00000000,
  parameter logic signed [31:0] LEAK           = 32'sh00F00000,
  parameter int unsigned        REFRACT_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  q8_24_lif_neuron_if.slave nif
);

  localparam int unsigned CNT_W = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

  lif_state_e                state_q, state_d;
  logic signed [Q_WIDTH-1:0] v_mem_q, v_mem_d;
  logic signed [Q_WIDTH-1:0] i_reg_q, i_reg_d;
  logic                      spike_q, spike_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic signed [Q_WIDTH-1:0] leak_prod;
  logic signed [Q_WIDTH-1:0] v_next;
  logic                      ready;
  logic                      xfer;

  Q8_24_multiplier u_mult (
    .a    (v_mem_q),
    .b    (LEAK),
    .prod (leak_prod)
  );

  assign v_next = sat_add(leak_prod, i_reg_q);
  assign ready  = (state_q == IDLE) || (state_q == REFRACT);
  assign xfer   = nif.in_valid && ready;

  // Next-state and datapath update; REFRACT accepts samples but never uses them.
  always_comb begin
    state_d = state_q;
    v_mem_d = v_mem_q;
    i_reg_d = i_reg_q;
    spike_d = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          i_reg_d = nif.in_current;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (v_next >= THRESHOLD) begin
          v_mem_d = V_RESET;
          spike_d = 1'b1;
          cnt_d   = CNT_W'(REFRACT_CYCLES);
          state_d = (REFRACT_CYCLES == 0) ? IDLE : REFRACT;
        end else begin
          v_mem_d = v_next;
          state_d = IDLE;
        end
      end
      REFRACT: begin
        v_mem_d = V_RESET;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset taking priority over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      v_mem_q <= '0;
      i_reg_q <= '0;
      spike_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      v_mem_q <= v_mem_d;
      i_reg_q <= i_reg_d;
      spike_q <= spike_d;
      cnt_q   <= cnt_d;
    end
  end

  assign nif.in_ready   = ready;
  assign nif.spike      = spike_q;
  assign nif.v_mem      = v_mem_q;
  assign nif.refractory = (state_q == REFRACT);

endmodule
